load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_if.sv | 41 ++++
 rtl/lsu_load_align.sv | 30 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// fault causes and the byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Access size lives in funct3[1:0] for both signed and unsigned loads.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << offset;
      2'b01:   return 4'b0011 << {offset[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side, memory-side and writeback-side signals of the load/store unit.
// slave = the LSU itself, master = its surroundings.
interface lsu_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            ex_valid;
  logic            ex_load;
  logic            ex_store;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_wdata;
  logic [RD_W-1:0] ex_rd;
  logic            ex_ready;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            fault;
  logic [1:0]      fault_cause;

  modport slave (
    input  ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
    input  mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_valid, wb_rd, wb_data, fault, fault_cause
  );

  modport master (
    output ex_valid, ex_load, ex_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
    output mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_valid, wb_rd, wb_data, fault, fault_cause
  );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed lane from a read word and sign/zero-extends it.
// Purely combinational so a cache path can share it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lane;

  assign lane = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: validates an execute-stage memory op, runs one req/ack
// transaction against data memory and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            fault_q, fault_d;
  logic [1:0]      cause_q, cause_d;

  logic            illegal;
  logic            misaligned;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_lanes;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i (bus.mem_rdata),
    .offset_i(off_q),
    .funct3_i(f3_q),
    .data_o  (load_data)
  );

  assign illegal = (bus.ex_load == bus.ex_store)
                 || (bus.ex_load  && (bus.ex_funct3 == 3'b011 || bus.ex_funct3[2:1] == 2'b11))
                 || (bus.ex_store && (bus.ex_funct3 > F3_W));

  assign misaligned = (bus.ex_funct3[1:0] == 2'b01 && bus.ex_addr[0])
                   || (bus.ex_funct3[1:0] == 2'b10 && bus.ex_addr[1:0] != 2'b00);

  always_comb begin
    case (bus.ex_funct3[1:0])
      2'b00:   store_lanes = {4{bus.ex_wdata[7:0]}};
      2'b01:   store_lanes = {2{bus.ex_wdata[15:0]}};
      default: store_lanes = bus.ex_wdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    off_d     = off_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    fault_d   = 1'b0;
    cause_d   = cause_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          // Rejected ops never reach memory; illegal wins over misaligned.
          if (illegal) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (misaligned) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            addr_d  = {bus.ex_addr[XLEN-1:2], 2'b00};
            be_d    = byte_enable(bus.ex_funct3, bus.ex_addr[1:0]);
            wdata_d = store_lanes;
            we_d    = bus.ex_store;
            off_d   = bus.ex_addr[1:0];
            f3_d    = bus.ex_funct3;
            rd_d    = bus.ex_rd;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            wb_data_d = load_data;
            state_d   = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      off_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      fault_q   <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  // Handshake outputs decode the state so an async reset drops them at once.
  assign bus.ex_ready    = (state_q == IDLE);
  assign bus.mem_req     = (state_q == REQ);
  assign bus.wb_valid    = (state_q == RESP);
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_be      = be_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;

endmodule
